cell_select_decoder: RTL and testbench
======================================

// Module: cell_select_decoder
// PURPOSE
//  Registered, parametrised successor to the board-cell decoder. Converts a cell index into a
//  one-cycle one-hot write-enable for N_CELLS board cells, and tracks occupancy and player turn.
//  Rejects moves to an occupied cell or an out-of-range index. Sits between move input and cell registers.
// PARAMETERS
//  N_CELLS  9  number of board cells / enable outputs (2..2**SEL_W)
//  SEL_W    4  width of cell index
// PORTS
//  clock      in   1        rising-edge system clock
//  reset_n    in   1        asynchronous, active-low reset
//  sel        in   SEL_W    requested cell index, 0-based
//  sel_valid  in   1        move request strobe, sampled each rising edge
//  clear      in   1        synchronous new-game clear
//  en         out  N_CELLS  one-hot cell write-enable, 1-cycle pulse
//  player     out  1        player owning the pulsed move (0=X, 1=O), valid while accept=1
//  accept     out  1        1-cycle pulse: move taken
//  reject     out  1        1-cycle pulse: move refused
//  occupied   out  N_CELLS  occupancy bitmap, bit i = cell i taken
//  turn       out  1        player to move next (0=X, 1=O)
//  full       out  1        all cells occupied (occupied == all ones)
// BEHAVIOUR
//  - Reset (async, reset_n=0): en=0, accept=0, reject=0, player=0, occupied=0, turn=0, state=PLAY.
//    Reset mid-operation discards any in-flight request; no pulse is emitted after release.
//  - All outputs registered. Latency: request at edge k -> en/accept/reject are valid after edge k.
//    All pulses are exactly one cycle wide unless sel_valid is held; each valid cycle is a new request.
//  - FSM states: PLAY, FULL.
//    PLAY: when sel_valid=1:
//      legal (sel < N_CELLS and occupied[sel]=0): en = 1<<sel, accept=1, player=turn,
//        occupied[sel] <= 1, turn <= ~turn; if this fills the last free cell, next state = FULL.
//      illegal (sel >= N_CELLS or occupied[sel]=1): en=0, reject=1, occupied and turn unchanged.
//    FULL: sel_valid=1 -> reject=1; no en, no state change.
//    sel_valid=0 -> en=0, accept=0, reject=0.
//  - clear=1: next cycle occupied=0, turn=0, state=PLAY, en/accept/reject=0.
//    clear has priority over a simultaneous sel_valid: the request is dropped without a reject pulse.
//  - Exactly one of {accept, reject} may be high in a cycle; en is nonzero iff accept=1,
//    and en is one-hot whenever nonzero.
//  - full is combinational from the occupied register (no extra latency); full=1 iff state=FULL.
//  - Index compare is unsigned over SEL_W bits. Indices N_CELLS..2**SEL_W-1 are out of range.
// TESTING
//  1. Reset, then sel=0..8 with sel_valid for one cycle each -> en=001h,002h,...,100h;
//     players alternate 0,1,0,...; occupied=1FFh; full=1 after the 9th move.
//  2. sel=4 accepted, then sel=4 again -> second request gives reject=1, en=0, turn unchanged (1).
//  3. sel=9 and sel=15 from reset -> reject=1, en=0, occupied=0, turn=0.
//  4. Board full, then sel_valid with sel=2 -> reject=1, state stays FULL.
//     Then clear -> occupied=0, turn=0, full=0.
//  5. clear=1 and sel_valid=1 (sel=3) in the same cycle -> occupied=0, no accept, no reject.
//  6. Three moves accepted, assert reset_n=0 mid-cycle -> all outputs 0 immediately,
//     before the next clock edge; after release, sel=0 accepted as player 0.
//  Also run N_CELLS=16, SEL_W=4 (no out-of-range index) and N_CELLS=5, SEL_W=3.

Source files
------------

// File: rtl/cell_select_decoder.sv
// rtl/cell_select_decoder.sv - registered cell-index to one-hot write-enable decoder with occupancy and turn tracking
module cell_select_decoder #(
  parameter int N_CELLS = 9,
  parameter int SEL_W   = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_valid,
  input  logic               clear,
  output logic [N_CELLS-1:0] en,
  output logic               player,
  output logic               accept,
  output logic               reject,
  output logic [N_CELLS-1:0] occupied,
  output logic               turn,
  output logic               full
);

  localparam int SPAN = 2 ** SEL_W;

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [N_CELLS-1:0] occ_nxt, en_nxt, sel_hot, occ_after;
  logic [SPAN-1:0]    occ_ext;
  logic               turn_nxt, player_nxt, accept_nxt, reject_nxt;
  logic               legal;

  // Indices past the last cell read as taken, so one lookup covers both range and occupancy.
  always_comb begin
    occ_ext = '1;
    for (int i = 0; i < N_CELLS; i++) begin
      occ_ext[i] = occupied[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_CELLS; i++) begin
      sel_hot[i] = (sel == SEL_W'(i));
    end
  end

  assign legal     = ~occ_ext[sel];
  assign occ_after = occupied | sel_hot;
  assign full      = &occupied;

  always_comb begin
    state_nxt  = state;
    occ_nxt    = occupied;
    turn_nxt   = turn;
    player_nxt = player;
    en_nxt     = '0;
    accept_nxt = 1'b0;
    reject_nxt = 1'b0;
    if (clear) begin
      // A request arriving with clear is dropped silently.
      occ_nxt   = '0;
      turn_nxt  = 1'b0;
      state_nxt = ST_PLAY;
    end else if (sel_valid) begin
      if (state == ST_PLAY && legal) begin
        en_nxt     = sel_hot;
        accept_nxt = 1'b1;
        player_nxt = turn;
        occ_nxt    = occ_after;
        turn_nxt   = ~turn;
        if (&occ_after) begin
          state_nxt = ST_FULL;
        end
      end else begin
        reject_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_PLAY;
      occupied <= '0;
      turn     <= 1'b0;
      player   <= 1'b0;
      en       <= '0;
      accept   <= 1'b0;
      reject   <= 1'b0;
    end else begin
      state    <= state_nxt;
      occupied <= occ_nxt;
      turn     <= turn_nxt;
      player   <= player_nxt;
      en       <= en_nxt;
      accept   <= accept_nxt;
      reject   <= reject_nxt;
    end
  end

endmodule

// File: tb/tb_cell_select_decoder.sv
// tb/tb_cell_select_decoder.sv - scoreboard bench for cell_select_decoder at 9, 16 and 5 cells
module tb_cell_select_decoder;

  typedef struct {
    int          inst;
    logic [15:0] en;
    logic        acc;
    logic        rej;
    logic        ply;
    logic [15:0] occ;
    logic        turn;
    logic        full;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  sel_i [3];
  logic        sv_i  [3];
  logic        clr_i [3];

  logic [8:0]  en0, occ0;
  logic [15:0] en1, occ1;
  logic [4:0]  en2, occ2;
  logic        ply0, acc0, rej0, turn0, full0;
  logic        ply1, acc1, rej1, turn1, full1;
  logic        ply2, acc2, rej2, turn2, full2;

  logic [15:0] en_o  [3];
  logic [15:0] occ_o [3];
  logic        ply_o [3];
  logic        acc_o [3];
  logic        rej_o [3];
  logic        turn_o[3];
  logic        full_o[3];

  logic [15:0] m_occ [3];
  logic        m_turn[3];
  logic [15:0] m_mask[3];
  int          ncells[3];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  cell_select_decoder #(.N_CELLS(9), .SEL_W(4)) dut9 (
    .clock(clock), .reset_n(reset_n), .sel(sel_i[0]), .sel_valid(sv_i[0]), .clear(clr_i[0]),
    .en(en0), .player(ply0), .accept(acc0), .reject(rej0), .occupied(occ0), .turn(turn0), .full(full0)
  );

  cell_select_decoder #(.N_CELLS(16), .SEL_W(4)) dut16 (
    .clock(clock), .reset_n(reset_n), .sel(sel_i[1]), .sel_valid(sv_i[1]), .clear(clr_i[1]),
    .en(en1), .player(ply1), .accept(acc1), .reject(rej1), .occupied(occ1), .turn(turn1), .full(full1)
  );

  cell_select_decoder #(.N_CELLS(5), .SEL_W(3)) dut5 (
    .clock(clock), .reset_n(reset_n), .sel(sel_i[2][2:0]), .sel_valid(sv_i[2]), .clear(clr_i[2]),
    .en(en2), .player(ply2), .accept(acc2), .reject(rej2), .occupied(occ2), .turn(turn2), .full(full2)
  );

  always_comb begin
    en_o[0]  = 16'(en0);  en_o[1]  = en1;  en_o[2]  = 16'(en2);
    occ_o[0] = 16'(occ0); occ_o[1] = occ1; occ_o[2] = 16'(occ2);
    ply_o[0] = ply0;  ply_o[1] = ply1;  ply_o[2] = ply2;
    acc_o[0] = acc0;  acc_o[1] = acc1;  acc_o[2] = acc2;
    rej_o[0] = rej0;  rej_o[1] = rej1;  rej_o[2] = rej2;
    turn_o[0] = turn0; turn_o[1] = turn1; turn_o[2] = turn2;
    full_o[0] = full0; full_o[1] = full1; full_o[2] = full2;
  end

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_occ[k]  = '0;
      m_turn[k] = 1'b0;
    end
    sb.delete();
  endtask

  // Drive one cycle on instance k, predict its outcome, then score the registered result.
  task automatic drive_and_score(input string tag, input int k, input logic [3:0] s,
                                 input logic v, input logic c);
    exp_t e;
    sel_i[k] = s; sv_i[k] = v; clr_i[k] = c;
    e.inst = k; e.en = '0; e.acc = 1'b0; e.rej = 1'b0; e.ply = 1'b0;
    if (c) begin
      m_occ[k]  = '0;
      m_turn[k] = 1'b0;
    end else if (v) begin
      if (int'(s) < ncells[k] && !m_occ[k][s]) begin
        e.en = 16'(1) << s;
        e.acc = 1'b1;
        e.ply = m_turn[k];
        m_occ[k][s] = 1'b1;
        m_turn[k] = ~m_turn[k];
      end else begin
        e.rej = 1'b1;
      end
    end
    e.occ  = m_occ[k];
    e.turn = m_turn[k];
    e.full = (m_occ[k] == m_mask[k]);
    sb.push_back(e);
    @(posedge clock); #1;
    sv_i[k] = 1'b0; clr_i[k] = 1'b0;
    e = sb.pop_front();
    checks++;
    if (en_o[e.inst] !== e.en) begin
      errors++; $display("FAIL %s en: got %h want %h", tag, en_o[e.inst], e.en);
    end
    checks++;
    if (acc_o[e.inst] !== e.acc || rej_o[e.inst] !== e.rej) begin
      errors++; $display("FAIL %s accept/reject: got %b/%b want %b/%b", tag,
                         acc_o[e.inst], rej_o[e.inst], e.acc, e.rej);
    end
    if (e.acc) begin
      checks++;
      if (ply_o[e.inst] !== e.ply) begin
        errors++; $display("FAIL %s player: got %b want %b", tag, ply_o[e.inst], e.ply);
      end
    end
    checks++;
    if (occ_o[e.inst] !== e.occ || turn_o[e.inst] !== e.turn || full_o[e.inst] !== e.full) begin
      errors++; $display("FAIL %s occ/turn/full: got %h/%b/%b want %h/%b/%b", tag,
                         occ_o[e.inst], turn_o[e.inst], full_o[e.inst], e.occ, e.turn, e.full);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sv_i[k] = 1'b0; clr_i[k] = 1'b0; sel_i[k] = '0;
    end
    model_reset();
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (en_o[k] !== 16'h0 || acc_o[k] !== 1'b0 || rej_o[k] !== 1'b0 || ply_o[k] !== 1'b0 ||
          occ_o[k] !== 16'h0 || turn_o[k] !== 1'b0 || full_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: got en=%h a=%b r=%b p=%b occ=%h t=%b f=%b want all zero", k,
                 en_o[k], acc_o[k], rej_o[k], ply_o[k], occ_o[k], turn_o[k], full_o[k]);
      end
    end
  endtask

  task automatic test_fill_board();
    for (int i = 0; i < 9; i++) drive_and_score("fill", 0, 4'(i), 1'b1, 1'b0);
    checks++;
    if (occ0 !== 9'h1FF || full0 !== 1'b1) begin
      errors++; $display("FAIL fill_final: got occ=%h full=%b want 1ff/1", occ0, full0);
    end
  endtask

  task automatic test_occupied_reject();
    drive_and_score("occ_clear", 0, 4'd0, 1'b0, 1'b1);
    drive_and_score("occ_first", 0, 4'd4, 1'b1, 1'b0);
    drive_and_score("occ_again", 0, 4'd4, 1'b1, 1'b0);
    checks++;
    if (turn0 !== 1'b1 || rej0 !== 1'b1) begin
      errors++; $display("FAIL occ_turn: got turn=%b reject=%b want 1/1", turn0, rej0);
    end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    drive_and_score("oor_9", 0, 4'd9, 1'b1, 1'b0);
    drive_and_score("oor_15", 0, 4'd15, 1'b1, 1'b0);
    drive_and_score("idle", 0, 4'd1, 1'b0, 1'b0);
  endtask

  task automatic test_full_reject();
    for (int i = 8; i >= 0; i--) drive_and_score("full_fill", 0, 4'(i), 1'b1, 1'b0);
    drive_and_score("full_rej", 0, 4'd2, 1'b1, 1'b0);
    drive_and_score("full_rej2", 0, 4'd12, 1'b1, 1'b0);
    drive_and_score("full_clear", 0, 4'd0, 1'b0, 1'b1);
    checks++;
    if (full0 !== 1'b0 || occ0 !== 9'h0 || turn0 !== 1'b0) begin
      errors++; $display("FAIL full_after_clear: got full=%b occ=%h turn=%b want 0/0/0", full0, occ0, turn0);
    end
  endtask

  task automatic test_clear_priority();
    drive_and_score("clr_pre", 0, 4'd7, 1'b1, 1'b0);
    drive_and_score("clr_pri", 0, 4'd3, 1'b1, 1'b1);
    drive_and_score("clr_post", 0, 4'd3, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    drive_and_score("ar_m0", 0, 4'd1, 1'b1, 1'b0);
    drive_and_score("ar_m1", 0, 4'd5, 1'b1, 1'b0);
    sel_i[0] = 4'd6; sv_i[0] = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (en0 !== 9'h0 || acc0 !== 1'b0 || rej0 !== 1'b0 || ply0 !== 1'b0 ||
        occ0 !== 9'h0 || turn0 !== 1'b0 || full0 !== 1'b0) begin
      errors++; $display("FAIL async_reset: got en=%h a=%b occ=%h t=%b p=%b want all zero",
                         en0, acc0, occ0, turn0, ply0);
    end
    model_reset();
    @(posedge clock); #1;
    sv_i[0] = 1'b0;
    reset_n = 1'b1;
    drive_and_score("ar_idle", 0, 4'd0, 1'b0, 1'b0);
    drive_and_score("ar_after", 0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic test_n16();
    for (int i = 0; i < 16; i++) drive_and_score("n16_fill", 1, 4'(i), 1'b1, 1'b0);
    checks++;
    if (full1 !== 1'b1 || occ1 !== 16'hFFFF) begin
      errors++; $display("FAIL n16_full: got full=%b occ=%h want 1/ffff", full1, occ1);
    end
    drive_and_score("n16_rej", 1, 4'd15, 1'b1, 1'b0);
  endtask

  task automatic test_n5();
    drive_and_score("n5_oor5", 2, 4'd5, 1'b1, 1'b0);
    drive_and_score("n5_oor7", 2, 4'd7, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive_and_score("n5_fill", 2, 4'(4 - i), 1'b1, 1'b0);
    checks++;
    if (full2 !== 1'b1 || occ2 !== 5'h1F) begin
      errors++; $display("FAIL n5_full: got full=%b occ=%h want 1/1f", full2, occ2);
    end
  endtask

  initial begin
    ncells[0] = 9;  m_mask[0] = 16'h01FF;
    ncells[1] = 16; m_mask[1] = 16'hFFFF;
    ncells[2] = 5;  m_mask[2] = 16'h001F;
    test_reset();
    test_fill_board();
    test_occupied_reject();
    test_out_of_range();
    test_full_reject();
    test_clear_priority();
    test_async_reset();
    test_n16();
    test_n5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
